// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard tracker.
// The MDU stall term is enabled by defining HAZARD_MDU_STALL_EN.
package hazard_pkg;

   localparam int TNEW_WIDTH = 2;

   typedef logic [TNEW_WIDTH-1:0] tnew_t;

   localparam tnew_t TUSE_NONE = 2'd3;
   localparam tnew_t TNEW_LUI  = 2'd0;
   localparam tnew_t TNEW_ALU  = 2'd1;
   localparam tnew_t TNEW_LOAD = 2'd2;

   typedef struct packed {
      logic [4:0] reg_addr;
      logic       reg_write;
      tnew_t      tnew;
   } slot_t;

   localparam slot_t BUBBLE = '0;

   // Count Tnew down by one stage, clamping at zero so a ready result stays ready.
   function automatic tnew_t sat0_dec(input tnew_t t);
      return (t == '0) ? '0 : t - tnew_t'(1);
   endfunction

endpackage

// File: rtl/hazard_slot.sv
// One pipeline-stage slot {reg_addr, reg_write, tnew}.
// Loads every edge and takes a bubble when told to.
module hazard_slot
   import hazard_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  bubble,
   input  slot_t slot_in,
   output slot_t slot_q
);

   slot_t slot_d;

   always_comb begin
      slot_d = bubble ? BUBBLE : slot_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) slot_q <= BUBBLE;
      else       slot_q <= slot_d;
   end

endmodule

// File: rtl/hazard_tracker.sv
// Tracks in-flight destinations in E/M/W and computes the D-stage stall.
// Define HAZARD_MDU_STALL_EN to add the multiply/divide unit stall term and its ports.
module hazard_tracker
   import hazard_pkg::*;
#(
   parameter int TNEW_W = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        D_RsAddr,
   input  logic [4:0]        D_RtAddr,
   input  logic [TNEW_W-1:0] D_TuseRs,
   input  logic [TNEW_W-1:0] D_TuseRt,
   input  logic [4:0]        D_RegAddr,
   input  logic              D_RegWrite,
   input  logic [TNEW_W-1:0] D_Tnew,
   input  logic              flush,
`ifdef HAZARD_MDU_STALL_EN
   input  logic              D_IsMdu,
   input  logic              D_MduStart,
   input  logic              mdu_busy,
`endif
   output logic [4:0]        E_RegAddr,
   output logic [4:0]        M_RegAddr,
   output logic [4:0]        W_RegAddr,
   output logic              E_RegWrite,
   output logic              M_RegWrite,
   output logic              W_RegWrite,
   output logic [TNEW_W-1:0] E_Tnew,
   output logic [TNEW_W-1:0] M_Tnew,
   output logic              stall
);

   slot_t e_in, m_in, w_in;
   slot_t e_q, m_q, w_q;
   logic  reg_stall;
   logic  mdu_stall;
   logic  w_tnew_unused;

   // A source waits while its producer's result is not ready by the time it is used.
   function automatic logic src_hazard(input logic [4:0] src, input tnew_t tuse, input slot_t s);
      return (src != 5'd0) && (tuse < s.tnew) && (src == s.reg_addr) && s.reg_write;
   endfunction

   always_comb begin
      reg_stall = src_hazard(D_RsAddr, D_TuseRs, e_q) ||
                  src_hazard(D_RsAddr, D_TuseRs, m_q) ||
                  src_hazard(D_RtAddr, D_TuseRt, e_q) ||
                  src_hazard(D_RtAddr, D_TuseRt, m_q);
   end

`ifdef HAZARD_MDU_STALL_EN
   logic e_mdu_start_q, e_mdu_start_d;

   always_comb begin
      e_mdu_start_d = (flush || stall) ? 1'b0 : D_MduStart;
      mdu_stall     = D_IsMdu && (e_mdu_start_q || mdu_busy);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) e_mdu_start_q <= 1'b0;
      else       e_mdu_start_q <= e_mdu_start_d;
   end
`else
   always_comb begin
      mdu_stall = 1'b0;
   end
`endif

   always_comb begin
      stall          = reg_stall || mdu_stall;
      e_in.reg_addr  = D_RegAddr;
      e_in.reg_write = D_RegWrite;
      e_in.tnew      = D_Tnew;
      m_in.reg_addr  = e_q.reg_addr;
      m_in.reg_write = e_q.reg_write;
      m_in.tnew      = sat0_dec(e_q.tnew);
      w_in.reg_addr  = m_q.reg_addr;
      w_in.reg_write = m_q.reg_write;
      w_in.tnew      = TNEW_LUI;
   end

   // Flush wins over stall: both bubble E, only flush bubbles M and W.
   hazard_slot u_slot_e (.clk(clk), .reset(reset), .bubble(flush || stall), .slot_in(e_in), .slot_q(e_q));
   hazard_slot u_slot_m (.clk(clk), .reset(reset), .bubble(flush),          .slot_in(m_in), .slot_q(m_q));
   hazard_slot u_slot_w (.clk(clk), .reset(reset), .bubble(flush),          .slot_in(w_in), .slot_q(w_q));

   assign E_RegAddr     = e_q.reg_addr;
   assign M_RegAddr     = m_q.reg_addr;
   assign W_RegAddr     = w_q.reg_addr;
   assign E_RegWrite    = e_q.reg_write;
   assign M_RegWrite    = m_q.reg_write;
   assign W_RegWrite    = w_q.reg_write;
   assign E_Tnew        = e_q.tnew;
   assign M_Tnew        = m_q.tnew;
   assign w_tnew_unused = ^w_q.tnew;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed self-checking bench for hazard_tracker.
// Exercises the MDU stall path when HAZARD_MDU_STALL_EN is defined.
module tb_hazard_tracker;

   logic       clk;
   logic       reset;
   logic [4:0] D_RsAddr, D_RtAddr, D_RegAddr;
   logic [1:0] D_TuseRs, D_TuseRt, D_Tnew;
   logic       D_RegWrite, flush;
   logic       D_IsMdu, D_MduStart, mdu_busy;
   logic [4:0] E_RegAddr, M_RegAddr, W_RegAddr;
   logic       E_RegWrite, M_RegWrite, W_RegWrite;
   logic [1:0] E_Tnew, M_Tnew;
   logic       stall;

   int checks;
   int failures;

   hazard_tracker #(.TNEW_W(2)) dut (
      .clk(clk), .reset(reset),
      .D_RsAddr(D_RsAddr), .D_RtAddr(D_RtAddr),
      .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt),
      .D_RegAddr(D_RegAddr), .D_RegWrite(D_RegWrite), .D_Tnew(D_Tnew),
      .flush(flush),
`ifdef HAZARD_MDU_STALL_EN
      .D_IsMdu(D_IsMdu), .D_MduStart(D_MduStart), .mdu_busy(mdu_busy),
`endif
      .E_RegAddr(E_RegAddr), .M_RegAddr(M_RegAddr), .W_RegAddr(W_RegAddr),
      .E_RegWrite(E_RegWrite), .M_RegWrite(M_RegWrite), .W_RegWrite(W_RegWrite),
      .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
      .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic [4:0] rs, input logic [1:0] tuse_rs,
                        input logic [4:0] rt, input logic [1:0] tuse_rt,
                        input logic [4:0] dst, input logic rw, input logic [1:0] tnew);
      D_RsAddr   = rs;
      D_TuseRs   = tuse_rs;
      D_RtAddr   = rt;
      D_TuseRt   = tuse_rt;
      D_RegAddr  = dst;
      D_RegWrite = rw;
      D_Tnew     = tnew;
      D_IsMdu    = 1'b0;
      D_MduStart = 1'b0;
   endtask

   task automatic nop_drain();
      set_d(0, 3, 0, 3, 0, 0, 0);
      repeat (3) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      mdu_busy = 1'b0;
      set_d(0, 3, 0, 3, 0, 0, 0);
      step();
      step();
      checks++;
      if ({E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_RegWrite, M_Tnew, W_RegAddr, W_RegWrite} !== 23'd0) begin
         failures++;
         $display("FAIL reset_slots got=%h exp=0", {E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_RegWrite, M_Tnew, W_RegAddr, W_RegWrite});
      end
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL reset_stall got=%b exp=0", stall);
      end
      reset = 1'b0;
      #1;
   endtask

   task automatic test_latency();
      set_d(0, 3, 0, 3, 9, 1, 1);
      step();
      set_d(0, 3, 0, 3, 4, 1, 0);
      checks++;
      if ({E_RegAddr, E_RegWrite, E_Tnew} !== {5'd9, 1'b1, 2'd1}) begin
         failures++;
         $display("FAIL lat_e got=%h exp=%h", {E_RegAddr, E_RegWrite, E_Tnew}, {5'd9, 1'b1, 2'd1});
      end
      step();
      set_d(0, 3, 0, 3, 0, 0, 0);
      checks++;
      if ({M_RegAddr, M_RegWrite, M_Tnew, E_RegAddr, E_Tnew} !== {5'd9, 1'b1, 2'd0, 5'd4, 2'd0}) begin
         failures++;
         $display("FAIL lat_m got=%h exp=%h", {M_RegAddr, M_RegWrite, M_Tnew, E_RegAddr, E_Tnew}, {5'd9, 1'b1, 2'd0, 5'd4, 2'd0});
      end
      step();
      checks++;
      if ({W_RegAddr, W_RegWrite, M_RegAddr, M_Tnew} !== {5'd9, 1'b1, 5'd4, 2'd0}) begin
         failures++;
         $display("FAIL lat_w_sat0 got=%h exp=%h", {W_RegAddr, W_RegWrite, M_RegAddr, M_Tnew}, {5'd9, 1'b1, 5'd4, 2'd0});
      end
      nop_drain();
   endtask

   task automatic test_load_use_tuse1();
      set_d(0, 3, 0, 3, 2, 1, 2);
      step();
      set_d(2, 1, 0, 3, 0, 0, 1);
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL lu1_stall got=%b exp=1", stall);
      end
      step();
      #1;
      checks++;
      if ({E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_Tnew, stall} !== {5'd0, 1'b0, 2'd0, 5'd2, 2'd1, 1'b0}) begin
         failures++;
         $display("FAIL lu1_after got=%h exp=%h", {E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_Tnew, stall}, {5'd0, 1'b0, 2'd0, 5'd2, 2'd1, 1'b0});
      end
      nop_drain();
   endtask

   task automatic test_load_use_tuse0();
      set_d(0, 3, 0, 3, 3, 1, 2);
      step();
      set_d(0, 3, 3, 0, 0, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL lu0_stall1 got=%b exp=1", stall);
      end
      step();
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL lu0_stall2 got=%b exp=1", stall);
      end
      step();
      #1;
      checks++;
      if ({stall, W_RegAddr, W_RegWrite} !== {1'b0, 5'd3, 1'b1}) begin
         failures++;
         $display("FAIL lu0_release got=%h exp=%h", {stall, W_RegAddr, W_RegWrite}, {1'b0, 5'd3, 1'b1});
      end
      nop_drain();
   endtask

   task automatic test_alu_use();
      set_d(0, 3, 0, 3, 5, 1, 1);
      step();
      set_d(5, 1, 0, 3, 0, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL alu_tuse1 got=%b exp=0", stall);
      end
      set_d(5, 0, 0, 3, 0, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL alu_tuse0 got=%b exp=1", stall);
      end
      step();
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL alu_release got=%b exp=0", stall);
      end
      nop_drain();
      set_d(0, 3, 0, 3, 6, 0, 2);
      step();
      set_d(6, 0, 6, 0, 0, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL nowrite_nostall got=%b exp=0", stall);
      end
      nop_drain();
   endtask

   task automatic test_zero_reg();
      set_d(0, 3, 0, 3, 0, 1, 2);
      step();
      set_d(0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL zero_e got=%b exp=0", stall);
      end
      step();
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL zero_m got=%b exp=0", stall);
      end
      nop_drain();
   endtask

   task automatic fill_pipe();
      set_d(0, 3, 0, 3, 7, 1, 1);
      step();
      set_d(0, 3, 0, 3, 6, 1, 2);
      step();
      set_d(0, 3, 0, 3, 5, 1, 2);
      step();
      set_d(0, 3, 0, 3, 0, 0, 0);
   endtask

   task automatic test_flush_and_async_reset();
      fill_pipe();
      checks++;
      if ({E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_RegWrite, M_Tnew, W_RegAddr, W_RegWrite} !==
          {5'd5, 1'b1, 2'd2, 5'd6, 1'b1, 2'd1, 5'd7, 1'b1}) begin
         failures++;
         $display("FAIL fill got=%h exp=%h", {E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_RegWrite, M_Tnew, W_RegAddr, W_RegWrite},
                  {5'd5, 1'b1, 2'd2, 5'd6, 1'b1, 2'd1, 5'd7, 1'b1});
      end
      set_d(0, 3, 0, 3, 9, 1, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if ({E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_RegWrite, M_Tnew, W_RegAddr, W_RegWrite} !== 23'd0) begin
         failures++;
         $display("FAIL flush got=%h exp=0", {E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_RegWrite, M_Tnew, W_RegAddr, W_RegWrite});
      end
      fill_pipe();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_RegWrite, M_Tnew, W_RegAddr, W_RegWrite} !== 23'd0) begin
         failures++;
         $display("FAIL async_reset got=%h exp=0", {E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_RegWrite, M_Tnew, W_RegAddr, W_RegWrite});
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_stall_flush();
      set_d(0, 3, 0, 3, 2, 1, 2);
      step();
      set_d(2, 1, 0, 3, 8, 1, 1);
      flush = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL sf_pre got=%b exp=1", stall);
      end
      step();
      flush = 1'b0;
      #1;
      checks++;
      if ({E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_RegWrite, M_Tnew, W_RegAddr, W_RegWrite, stall} !== 24'd0) begin
         failures++;
         $display("FAIL sf_post got=%h exp=0", {E_RegAddr, E_RegWrite, E_Tnew, M_RegAddr, M_RegWrite, M_Tnew, W_RegAddr, W_RegWrite, stall});
      end
      nop_drain();
   endtask

   task automatic test_mdu();
`ifdef HAZARD_MDU_STALL_EN
      set_d(0, 3, 0, 3, 0, 0, 1);
      D_IsMdu = 1'b1;
      D_MduStart = 1'b1;
      step();
      set_d(0, 3, 0, 3, 8, 1, 1);
      D_IsMdu = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL mdu_start got=%b exp=1", stall);
      end
      mdu_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         #1;
         checks++;
         if (stall !== 1'b1) begin
            failures++;
            $display("FAIL mdu_busy_%0d got=%b exp=1", i, stall);
         end
      end
      mdu_busy = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL mdu_release got=%b exp=0", stall);
      end
`else
      set_d(0, 3, 0, 3, 0, 0, 1);
      step();
      set_d(0, 3, 0, 3, 8, 1, 1);
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL mdu_off got=%b exp=0", stall);
      end
`endif
      nop_drain();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      D_IsMdu = 1'b0;
      D_MduStart = 1'b0;
      test_reset();
      test_latency();
      test_load_use_tuse1();
      test_load_use_tuse0();
      test_alu_use();
      test_zero_reg();
      test_flush_and_async_reset();
      test_stall_flush();
      test_mdu();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
